prbs4_checker: RTL and testbench
================================

PRBS4_CHECKER -- requirements
Module: prbs4_checker

Interface
REQ-001 SHALL have parameter ERR_W, default 16: error counter width.
REQ-002 SHALL have parameter LOCK_LEN, default 8: consecutive correct predictions needed to lock.
REQ-003 SHALL have parameter WIN_LEN, default 16: loss-of-lock window length, in accepted bits.
REQ-004 SHALL have parameter LOSS_THRESH, default 4: errors within one window that force loss of lock.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  in_bit is accepted on this rising edge.
REQ-008 in_bit  input  1  received PRBS bit.
REQ-009 clear_cnt  input  1  synchronous clear of err_count.
REQ-010 locked  output  1  checker is in LOCKED state.
REQ-011 err_pulse  output  1  one-cycle pulse per bit error detected while LOCKED.
REQ-012 err_count  output  ERR_W  saturating count of bit errors detected while LOCKED.
REQ-013 state  output  2  current state: 0=HUNT, 1=VERIFY, 2=LOCKED.

Function
REQ-014 SHALL check a serial stream from the polynomial x^4+x^3+1 generator, where each new bit is gen[3]^gen[2] and the generator shifts left with the new bit entering at bit 0; period 15.
REQ-015 SHALL hold a 4-bit shift register sr; predicted bit = sr[3]^sr[2].
REQ-016 SHALL act only on cycles with in_valid=1; with in_valid=0 all state, counters and sr hold, and err_pulse=0.
REQ-017 HUNT: on each accepted bit, sr <= {sr[2:0], in_bit} and fill count increments.
REQ-018 HUNT: after 4 accepted bits, go to VERIFY if the new sr is nonzero; otherwise restart the fill count and stay in HUNT.
REQ-019 VERIFY: on each accepted bit, sr <= {sr[2:0], in_bit}; a match increments the match count.
REQ-020 VERIFY: on the LOCK_LEN-th consecutive match, go to LOCKED.
REQ-021 VERIFY: a mismatch clears the match count and returns to HUNT, with fill count = 0; sr keeps the shifted value.
REQ-022 LOCKED (flywheel): on each accepted bit, sr <= {sr[2:0], predicted}, so a received error does not corrupt the reference.
REQ-023 LOCKED: a mismatch asserts err_pulse for exactly the next cycle, increments err_count (saturates at 2^ERR_W-1, no wrap), and increments the window error count.
REQ-024 LOCKED: a window bit counter counts accepted bits 0..WIN_LEN-1.
REQ-025 LOCKED: when the window bit counter wraps, the window error count restarts at 0, or at 1 if that bit was an error.
REQ-026 LOCKED: when the window error count reaches LOSS_THRESH, go to HUNT, clear the fill, window and match counters, and keep err_count.
REQ-027 clear_cnt=1 SHALL set err_count to 0 on that edge; clear wins over a simultaneous error, but err_pulse still asserts.
REQ-028 All outputs SHALL be registered; locked and state reflect the new state the cycle after the deciding edge.
REQ-029 err_count SHALL never change outside LOCKED except through clear_cnt or reset.

Reset
REQ-030 reset=1 at a rising edge SHALL force state=HUNT, sr=0, all internal counters=0, locked=0, err_pulse=0 and err_count=0, in any state and overriding in_valid and clear_cnt.
REQ-031 Reset asserted mid-operation SHALL discard any partial fill or verify progress; re-lock requires a full 4+LOCK_LEN accepted bits after reset deasserts.

Verification
REQ-032 Reset, then stream 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1 repeated with in_valid=1 -> state=VERIFY after the 4th bit; locked=1 the cycle after the 12th bit; err_count stays 0.
REQ-033 While locked, flip one bit -> single-cycle err_pulse, err_count=1, locked stays 1, and following correct bits produce no further errors (flywheel).
REQ-034 While locked, flip 4 bits within 16 accepted bits -> err_count=4, state returns to HUNT, locked=0; the correct stream then re-locks 12 accepted bits later.
REQ-035 Constant-0 input -> checker never leaves HUNT, locked stays 0; in_valid gaps (random 0s) in the REQ-032 stream lock after the same 12 accepted bits.
REQ-036 ERR_W=4 with a continuous stream of errors while locked -> err_count saturates at 15 and does not wrap; clear_cnt coincident with an error -> err_count=0 and err_pulse=1.
REQ-037 Assert reset while LOCKED with err_count=5 -> next cycle state=0, locked=0, err_count=0.

Source files
------------

// File: rtl/prbs4_checker.sv
// PRBS4 (x^4+x^3+1) serial stream checker.
// Hunts for a nonzero 4-bit seed, verifies LOCK_LEN consecutive predictions,
// then flywheels on its own reference while counting bit errors. Too many
// errors inside one window of accepted bits drops lock and restarts the hunt.
module prbs4_checker #(
    parameter int unsigned ERR_W       = 16,
    parameter int unsigned LOCK_LEN    = 8,
    parameter int unsigned WIN_LEN     = 16,
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam int unsigned FILL_W  = 3;
    localparam int unsigned MATCH_W = $clog2(LOCK_LEN + 1);
    localparam int unsigned WBIT_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned WERR_W  = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         sr_q, sr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WBIT_W-1:0]  wbit_q, wbit_d;
    logic [WERR_W-1:0]  werr_q, werr_d;
    logic [ERR_W-1:0]   cnt_q, cnt_d;
    logic               pulse_q, pulse_d;
    logic               locked_q, locked_d;

    logic               predicted;
    logic               mismatch;
    logic [3:0]         sr_shift;
    logic               win_wrap;
    logic [WERR_W-1:0]  werr_next;

    // Prediction and shift helpers shared by all states.
    always_comb begin
        predicted = sr_q[3] ^ sr_q[2];
        mismatch  = in_bit ^ predicted;
        sr_shift  = {sr_q[2:0], in_bit};
        win_wrap  = (wbit_q == WBIT_W'(WIN_LEN - 1));
        if (win_wrap) begin
            werr_next = WERR_W'(mismatch);
        end else begin
            werr_next = werr_q + WERR_W'(mismatch);
        end
    end

    // Next-state, counter and output logic.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        match_d = match_q;
        wbit_d  = wbit_q;
        werr_d  = werr_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    sr_d = sr_shift;
                    if (fill_q == FILL_W'(3)) begin
                        fill_d = '0;
                        // An all-zero seed would lock the generator model up.
                        if (sr_shift != 4'd0) begin
                            state_d = VERIFY;
                        end
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    sr_d = sr_shift;
                    if (!mismatch) begin
                        if (match_q == MATCH_W'(LOCK_LEN - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            wbit_d  = '0;
                            werr_d  = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        state_d = HUNT;
                        match_d = '0;
                        fill_d  = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the reference advances on its own prediction.
                    sr_d   = {sr_q[2:0], predicted};
                    wbit_d = win_wrap ? '0 : (wbit_q + WBIT_W'(1));
                    werr_d = werr_next;
                    if (mismatch) begin
                        pulse_d = 1'b1;
                        if (cnt_q != {ERR_W{1'b1}}) begin
                            cnt_d = cnt_q + ERR_W'(1);
                        end
                    end
                    if (werr_next >= WERR_W'(LOSS_THRESH)) begin
                        state_d = HUNT;
                        fill_d  = '0;
                        wbit_d  = '0;
                        werr_d  = '0;
                        match_d = '0;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        if (clear_cnt) begin
            cnt_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HUNT;
            sr_q     <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            wbit_q   <= '0;
            werr_q   <= '0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            wbit_q   <= wbit_d;
            werr_q   <= werr_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            locked_q <= locked_d;
        end
    end

    assign state     = state_q;
    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_prbs4_checker.sv
// Directed bench for prbs4_checker: table-driven lock-up plus hand sequences
// for flywheel errors, loss of lock, reset, in_valid gaps and saturation.
module tb_prbs4_checker;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_bit, clear_cnt;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state;

    logic        reset4, in_valid4, in_bit4, clear_cnt4;
    logic        locked4, err_pulse4;
    logic [3:0]  err_count4;
    logic [1:0]  state4;

    int checks = 0;
    int errors = 0;
    int idx    = 0;
    int idx4   = 0;
    logic pat [15];

    typedef struct {
        logic        rst, v, b, clr;
        logic [1:0]  st;
        logic        lk, p;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [18];

    prbs4_checker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .state(state)
    );

    prbs4_checker #(.ERR_W(4), .LOCK_LEN(8), .WIN_LEN(16), .LOSS_THRESH(17)) dut4 (
        .clk(clk), .reset(reset4), .in_valid(in_valid4), .in_bit(in_bit4),
        .clear_cnt(clear_cnt4), .locked(locked4), .err_pulse(err_pulse4),
        .err_count(err_count4), .state(state4)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic v, logic b, logic clr,
                                logic [1:0] st, logic lk, logic p, logic [15:0] cnt);
        vec_t r;
        r.rst = rst; r.v = v; r.b = b; r.clr = clr;
        r.st = st; r.lk = lk; r.p = p; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic b, input logic c);
        reset = r; in_valid = v; in_bit = b; clear_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pat(input logic flip);
        step(1'b0, 1'b1, pat[idx] ^ flip, 1'b0);
        idx = (idx + 1) % 15;
    endtask

    task automatic step4(input logic r, input logic v, input logic b, input logic c);
        reset4 = r; in_valid4 = v; in_bit4 = b; clear_cnt4 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic flip, input logic c);
        step4(1'b0, 1'b1, pat[idx4] ^ flip, c);
        idx4 = (idx4 + 1) % 15;
    endtask

    initial begin
        int acc;
        logic [3:0] exp4;

        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Lock-up table: reset, stream with one gap before and one after lock.
        tbl[0]  = mk(1, 0, 0, 0, 2'd0, 0, 0, 16'd0);
        tbl[1]  = mk(0, 1, 0, 0, 2'd0, 0, 0, 16'd0);
        tbl[2]  = mk(0, 1, 0, 0, 2'd0, 0, 0, 16'd0);
        tbl[3]  = mk(0, 1, 0, 0, 2'd0, 0, 0, 16'd0);
        tbl[4]  = mk(0, 0, 1, 0, 2'd0, 0, 0, 16'd0);
        tbl[5]  = mk(0, 1, 1, 0, 2'd1, 0, 0, 16'd0);
        tbl[6]  = mk(0, 1, 0, 0, 2'd1, 0, 0, 16'd0);
        tbl[7]  = mk(0, 1, 0, 0, 2'd1, 0, 0, 16'd0);
        tbl[8]  = mk(0, 1, 1, 0, 2'd1, 0, 0, 16'd0);
        tbl[9]  = mk(0, 1, 1, 0, 2'd1, 0, 0, 16'd0);
        tbl[10] = mk(0, 1, 0, 0, 2'd1, 0, 0, 16'd0);
        tbl[11] = mk(0, 1, 1, 0, 2'd1, 0, 0, 16'd0);
        tbl[12] = mk(0, 1, 0, 0, 2'd1, 0, 0, 16'd0);
        tbl[13] = mk(0, 1, 1, 0, 2'd2, 1, 0, 16'd0);
        tbl[14] = mk(0, 0, 0, 0, 2'd2, 1, 0, 16'd0);
        tbl[15] = mk(0, 1, 1, 0, 2'd2, 1, 0, 16'd0);
        tbl[16] = mk(0, 1, 1, 0, 2'd2, 1, 0, 16'd0);
        tbl[17] = mk(0, 1, 1, 0, 2'd2, 1, 0, 16'd0);

        reset4 = 1'b1; in_valid4 = 1'b0; in_bit4 = 1'b0; clear_cnt4 = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].clr);
            chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
            chk($sformatf("tbl%0d_pulse", i), 32'(err_pulse), 32'(tbl[i].p));
            chk($sformatf("tbl%0d_count", i), 32'(err_count), 32'(tbl[i].cnt));
        end
        idx = 0;

        // Single flipped bit while locked, then flywheel keeps the reference.
        send_pat(1'b1);
        chk("flip1_pulse", 32'(err_pulse), 32'd1);
        chk("flip1_count", 32'(err_count), 32'd1);
        chk("flip1_locked", 32'(locked), 32'd1);
        for (int i = 0; i < 6; i++) begin
            send_pat(1'b0);
            chk($sformatf("fly%0d_pulse", i), 32'(err_pulse), 32'd0);
            chk($sformatf("fly%0d_count", i), 32'(err_count), 32'd1);
        end
        chk("fly_state", 32'(state), 32'd2);

        // Clear without a valid bit.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear_count", 32'(err_count), 32'd0);
        chk("clear_locked", 32'(locked), 32'd1);

        // Finish the current window (indices 10..15), then 4 errors in a new one.
        for (int i = 0; i < 6; i++) send_pat(1'b0);
        for (int k = 1; k <= 4; k++) begin
            send_pat(1'b1);
            chk($sformatf("loss%0d_pulse", k), 32'(err_pulse), 32'd1);
            chk($sformatf("loss%0d_count", k), 32'(err_count), 32'(k));
            chk($sformatf("loss%0d_state", k), 32'(state), (k == 4) ? 32'd0 : 32'd2);
            chk($sformatf("loss%0d_locked", k), 32'(locked), (k == 4) ? 32'd0 : 32'd1);
        end
        for (int k = 1; k <= 12; k++) begin
            send_pat(1'b0);
            if (k == 4 || k == 11) chk($sformatf("relock%0d_state", k), 32'(state), 32'd1);
            if (k == 12) begin
                chk("relock_state", 32'(state), 32'd2);
                chk("relock_locked", 32'(locked), 32'd1);
                chk("relock_count", 32'(err_count), 32'd4);
            end
        end

        // Reset while locked with err_count=5.
        send_pat(1'b1);
        chk("pre_rst_count", 32'(err_count), 32'd5);
        step(1'b1, 1'b1, ~pat[idx], 1'b0);
        idx = (idx + 1) % 15;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_count", 32'(err_count), 32'd0);
        chk("rst_pulse", 32'(err_pulse), 32'd0);

        // Reset mid-verify discards progress: full 12 bits needed afterwards.
        for (int k = 1; k <= 7; k++) send_pat(1'b0);
        chk("midv_state", 32'(state), 32'd1);
        step(1'b1, 1'b1, pat[idx], 1'b0);
        idx = (idx + 1) % 15;
        chk("midv_rst_state", 32'(state), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            send_pat(1'b0);
            if (k == 3) chk("midv3_state", 32'(state), 32'd0);
            if (k == 11) chk("midv11_state", 32'(state), 32'd1);
            if (k == 12) chk("midv12_locked", 32'(locked), 32'd1);
        end

        // Constant zero input never leaves HUNT.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("zero%0d_state", k), 32'(state), 32'd0);
        end
        chk("zero_locked", 32'(locked), 32'd0);

        // Random in_valid gaps: lock after exactly 12 accepted bits.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idx = 0;
        acc = 0;
        for (int i = 0; i < 200 && acc < 12; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
                chk($sformatf("gap%0d_pulse", i), 32'(err_pulse), 32'd0);
            end else begin
                send_pat(1'b0);
                acc++;
                if (acc == 4) chk("gap_verify", 32'(state), 32'd1);
                if (acc == 11) chk("gap_prelock", 32'(locked), 32'd0);
                if (acc == 12) chk("gap_lock", 32'(locked), 32'd1);
            end
        end
        chk("gap_accepted", 32'(acc), 32'd12);

        // Narrow counter: saturation at 15 and clear against an error.
        in_valid = 1'b0; clear_cnt = 1'b0;
        step4(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) send4(1'b0, 1'b0);
        chk("sat_lock", 32'(locked4), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            send4(1'b1, 1'b0);
            exp4 = (k > 15) ? 4'd15 : 4'(k);
            chk($sformatf("sat%0d_count", k), 32'(err_count4), 32'(exp4));
            chk($sformatf("sat%0d_pulse", k), 32'(err_pulse4), 32'd1);
        end
        chk("sat_locked", 32'(locked4), 32'd1);
        send4(1'b1, 1'b1);
        chk("clr_err_count", 32'(err_count4), 32'd0);
        chk("clr_err_pulse", 32'(err_pulse4), 32'd1);
        send4(1'b1, 1'b0);
        chk("after_clr_count", 32'(err_count4), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
